// File: rtl/sdram_bus_bridge.sv
// Bridges the 8-bit CPU bus onto a wider acknowledged memory agent port, one access per CPU cycle.
// cpu_clk is treated as a sampled level. Accesses that are never acknowledged are aborted by a timeout.
module sdram_bus_bridge #(
  parameter  int unsigned ADDR_W    = 24,
  parameter  int unsigned MEM_DW    = 16,
  parameter  int unsigned TIMEOUT   = 255,
  localparam int unsigned LANE_BITS = $clog2(MEM_DW / 8)
) (
  input  logic                        clk_50,
  input  logic                        rst,
  input  logic                        cpu_clk,
  input  logic [ADDR_W-1:0]           addr,
  input  logic                        sdram_cs,
  input  logic                        rwb,
  input  logic [7:0]                  data_in,
  output logic [7:0]                  data_out,
  output logic                        rdy,
  output logic                        err,
  output logic [ADDR_W-LANE_BITS-1:0] mem_address,
  output logic [MEM_DW/8-1:0]         mem_byte_enable,
  output logic                        mem_read,
  output logic                        mem_write,
  output logic [MEM_DW-1:0]           mem_write_data,
  input  logic                        mem_ack,
  input  logic [MEM_DW-1:0]           mem_read_data
);

  localparam int unsigned NUM_LANES = MEM_DW / 8;
  localparam int unsigned LANE_W    = (LANE_BITS == 0) ? 1 : LANE_BITS;
  localparam int unsigned CNT_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]                  r_state;
  logic                        r_cpu_clk_q;
  logic                        r_rwb;
  logic [LANE_W-1:0]           r_lane;
  logic [CNT_W-1:0]            r_cnt;
  logic [7:0]                  r_data_out;
  logic                        r_err;
  logic                        r_mem_read;
  logic                        r_mem_write;
  logic [ADDR_W-LANE_BITS-1:0] r_mem_address;
  logic [NUM_LANES-1:0]        r_mem_byte_enable;
  logic [MEM_DW-1:0]           r_mem_write_data;

  logic                        w_rise;
  logic                        w_timeout;
  logic [LANE_W-1:0]           w_lane;
  logic [ADDR_W-LANE_BITS-1:0] w_word;
  logic [MEM_DW-1:0]           w_shifted;
  logic [7:0]                  w_rd_byte;

  // A byte-wide memory has no lane bits; the whole CPU address is the word address.
  if (LANE_BITS == 0) begin : g_narrow
    assign w_lane = '0;
    assign w_word = addr;
  end else begin : g_wide
    assign w_lane = addr[LANE_BITS-1:0];
    assign w_word = addr[ADDR_W-1:LANE_BITS];
  end

  assign w_rise    = cpu_clk & ~r_cpu_clk_q;
  assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_LAST);
  assign w_shifted = mem_read_data >> {r_lane, 3'b000};
  assign w_rd_byte = w_shifted[7:0];

  always_ff @(posedge clk_50) begin
    if (rst) begin
      r_state           <= StIdle;
      r_cpu_clk_q       <= 1'b1;
      r_rwb             <= 1'b1;
      r_lane            <= '0;
      r_cnt             <= '0;
      r_data_out        <= 8'h00;
      r_err             <= 1'b0;
      r_mem_read        <= 1'b0;
      r_mem_write       <= 1'b0;
      r_mem_address     <= '0;
      r_mem_byte_enable <= '0;
      r_mem_write_data  <= '0;
    end else begin
      r_cpu_clk_q <= cpu_clk;
      r_err       <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_rise && sdram_cs) begin
            r_state           <= StReq;
            r_rwb             <= rwb;
            r_lane            <= w_lane;
            r_cnt             <= '0;
            r_mem_read        <= rwb;
            r_mem_write       <= ~rwb;
            r_mem_address     <= w_word;
            r_mem_byte_enable <= NUM_LANES'(1) << w_lane;
            r_mem_write_data  <= {NUM_LANES{data_in}};
          end
        end
        StReq: begin
          // Ack takes priority over a timeout landing on the same cycle.
          if (mem_ack) begin
            r_state     <= StDone;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            if (r_rwb) r_data_out <= w_rd_byte;
          end else if (w_timeout) begin
            r_state     <= StDone;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_err       <= 1'b1;
            if (r_rwb) r_data_out <= 8'hFF;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StDone: begin
          if (!cpu_clk) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign rdy             = (r_state != StReq);
  assign data_out        = r_data_out;
  assign err             = r_err;
  assign mem_read        = r_mem_read;
  assign mem_write       = r_mem_write;
  assign mem_address     = r_mem_address;
  assign mem_byte_enable = r_mem_byte_enable;
  assign mem_write_data  = r_mem_write_data;

endmodule
